galaxian_dl_ctrl: RTL and testbench

//  Sits between hps_io and the galaxian core, upstream of the core.

---
 rtl/galaxian_dl_ctrl.sv | 165 ++++++++++++++++
 tb/tb_galaxian_dl_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/galaxian_dl_ctrl.sv
// Download controller for the galaxian core.
// Splits the hps_io ioctl stream into the ROM write port, the game-variant
// byte and the DIP bytes, and holds the core in reset until a ROM image has
// fully loaded plus RST_HOLD cycles.
// Ports:
//   clk_sys, reset          clock and synchronous active-high reset
//   user_reset              level reset request, OR'd into core_reset
//   ioctl_download/wr/addr/dout/index   download stream from hps_io
//   dn_addr/dn_data/dn_wr   ROM write port to the core
//   mod_onehot, mod_valid   decoded variant select
//   dip0..dip2              DIP bytes
//   core_reset              reset to the core
//   rom_loaded              a ROM download has completed since reset
//   rom_overflow            sticky: ROM byte addressed at or beyond 64K
module galaxian_dl_ctrl #(
    parameter int unsigned ROM_INDEX = 0,
    parameter int unsigned MOD_INDEX = 1,
    parameter int unsigned DIP_INDEX = 254,
    parameter int unsigned NUM_MODS  = 18,
    parameter int unsigned RST_HOLD  = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                user_reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic [15:0]         dn_addr,
    output logic [7:0]          dn_data,
    output logic                dn_wr,
    output logic [NUM_MODS-1:0] mod_onehot,
    output logic                mod_valid,
    output logic [7:0]          dip0,
    output logic [7:0]          dip1,
    output logic [7:0]          dip2,
    output logic                core_reset,
    output logic                rom_loaded,
    output logic                rom_overflow
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic                loaded_set;

    logic                rom_sel;
    logic                rom_start;
    logic                rom_hi;
    logic                rom_acc;
    logic                rom_ovf;
    logic                mod_we;
    logic                dip_we;
    logic [7:0]          mod_code;
    logic [NUM_MODS-1:0] mod_onehot_nxt;
    logic                mod_valid_nxt;

    // Target decode for the current ioctl cycle
    assign rom_sel   = (ioctl_index == 8'(ROM_INDEX));
    assign rom_start = ioctl_download & rom_sel;
    assign rom_hi    = (ioctl_addr[24:16] != 9'd0);
    assign rom_acc   = (state == S_LOAD) & ioctl_wr & rom_sel & ~rom_hi;
    assign rom_ovf   = (state == S_LOAD) & ioctl_wr & rom_sel & rom_hi;
    assign mod_we    = ioctl_wr & (ioctl_index == 8'(MOD_INDEX)) & (ioctl_addr == 25'd0);
    assign dip_we    = ioctl_wr & (ioctl_index == 8'(DIP_INDEX)) & (ioctl_addr < 25'd3);

    // FSM state and hold counter register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic; a new ROM download restarts the load from HOLD or RUN
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        loaded_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rom_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_nxt    = S_HOLD;
                    hold_cnt_nxt = HOLD_W'(RST_HOLD - 1);
                end
            end
            S_HOLD: begin
                if (rom_start) begin
                    state_nxt = S_LOAD;
                end else if (hold_cnt == '0) begin
                    state_nxt  = S_RUN;
                    loaded_set = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (rom_start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Variant decode from the latched code; out-of-range codes decode to zero
    always_comb begin
        mod_onehot_nxt = '0;
        for (int i = 0; i < NUM_MODS; i++) begin
            mod_onehot_nxt[i] = (mod_code == 8'(i));
        end
        mod_valid_nxt = (32'(mod_code) < NUM_MODS);
    end

    // Registered datapath and status outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dn_addr      <= '0;
            dn_data      <= '0;
            dn_wr        <= 1'b0;
            mod_code     <= '0;
            mod_onehot   <= NUM_MODS'(1);
            mod_valid    <= 1'b1;
            dip0         <= 8'hFF;
            dip1         <= 8'hFF;
            dip2         <= 8'hFF;
            core_reset   <= 1'b1;
            rom_loaded   <= 1'b0;
            rom_overflow <= 1'b0;
        end else begin
            dn_wr <= rom_acc;
            if (rom_acc) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end
            if (rom_ovf) rom_overflow <= 1'b1;
            if (mod_we) mod_code <= ioctl_dout;
            mod_onehot <= mod_onehot_nxt;
            mod_valid  <= mod_valid_nxt;
            if (dip_we) begin
                case (ioctl_addr[1:0])
                    2'd0:    dip0 <= ioctl_dout;
                    2'd1:    dip1 <= ioctl_dout;
                    default: dip2 <= ioctl_dout;
                endcase
            end
            core_reset <= (state != S_RUN) | user_reset;
            rom_loaded <= rom_loaded | loaded_set;
        end
    end

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Self-checking bench for galaxian_dl_ctrl: directed steps with a ROM-write
// scoreboard popped whenever the DUT pulses dn_wr.
module tb_galaxian_dl_ctrl;

    logic        clk_sys;
    logic        reset;
    logic        user_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [17:0] mod_onehot;
    logic        mod_valid;
    logic [7:0]  dip0;
    logic [7:0]  dip1;
    logic [7:0]  dip2;
    logic        core_reset;
    logic        rom_loaded;
    logic        rom_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dn_wr  = 0;
    logic [23:0] rom_q[$];

    galaxian_dl_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .user_reset     (user_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .mod_onehot     (mod_onehot),
        .mod_valid      (mod_valid),
        .dip0           (dip0),
        .dip1           (dip1),
        .dip2           (dip2),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .rom_overflow   (rom_overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ROM byte; expected writes go to the scoreboard
    task automatic rom_wr(input logic [24:0] a, input logic [7:0] d, input bit accept);
        ioctl_index = 8'd0;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (accept) rom_q.push_back({a[15:0], d});
        tick(1);
        ioctl_wr = 1'b0;
        tick(1);
    endtask

    task automatic side_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        tick(1);
    endtask

    // Scoreboard: every dn_wr pulse must match the oldest expected ROM write
    always @(negedge clk_sys) begin
        if (dn_wr !== 1'b0) begin
            logic [23:0] exp_w;
            n_dn_wr++;
            n_checks++;
            if (rom_q.size() == 0) begin
                n_fail++;
                $error("FAIL dn_wr_unexpected: observed addr %0h data %0h expected no write", dn_addr, dn_data);
            end else begin
                exp_w = rom_q.pop_front();
                assert ({dn_addr, dn_data} === exp_w) else begin
                    n_fail++;
                    $error("FAIL dn_wr_payload: observed %0h expected %0h", {dn_addr, dn_data}, exp_w);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        user_reset     = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        tick(2);

        // Reset values
        chk("rst_dn_wr",      32'(dn_wr), 32'd0);
        chk("rst_dn_addr",    32'(dn_addr), 32'd0);
        chk("rst_dn_data",    32'(dn_data), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        chk("rst_overflow",   32'(rom_overflow), 32'd0);
        chk("rst_mod_onehot", 32'(mod_onehot), 32'h1);
        chk("rst_mod_valid",  32'(mod_valid), 32'd1);
        chk("rst_dips",       {8'h0, dip0, dip1, dip2}, 32'h00FFFFFF);
        reset = 1'b0;
        tick(1);

        // First ROM download, four bytes
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) rom_wr(25'(i), 8'hA0 + 8'(i), 1'b1);
        tick(1);
        chk("load_core_reset", 32'(core_reset), 32'd1);
        chk("load_dn_hold",    {8'h0, dn_addr, dn_data}, 32'h0003A3);
        ioctl_download = 1'b0;
        tick(16);
        chk("hold_rom_loaded_pre", 32'(rom_loaded), 32'd0);
        tick(1);
        chk("hold_core_reset_17", 32'(core_reset), 32'd1);
        chk("hold_rom_loaded",    32'(rom_loaded), 32'd1);
        tick(1);
        chk("run_core_reset", 32'(core_reset), 32'd0);

        // Variant byte
        side_wr(8'd1, 25'd0, 8'h05);
        chk("mod5_onehot", 32'(mod_onehot), 32'h00020);
        chk("mod5_valid",  32'(mod_valid), 32'd1);
        side_wr(8'd1, 25'd1, 8'h03);
        chk("mod_addr1_ignored", 32'(mod_onehot), 32'h00020);
        side_wr(8'd1, 25'd0, 8'h11);
        chk("mod17_onehot", 32'(mod_onehot), 32'h20000);
        chk("mod17_valid",  32'(mod_valid), 32'd1);
        side_wr(8'd1, 25'd0, 8'h12);
        chk("mod18_onehot", 32'(mod_onehot), 32'h0);
        chk("mod18_valid",  32'(mod_valid), 32'd0);
        side_wr(8'd1, 25'd0, 8'h20);
        chk("mod20_onehot", 32'(mod_onehot), 32'h0);
        chk("mod20_valid",  32'(mod_valid), 32'd0);

        // DIP bytes; addr 3, 5 and 0x100 leave them unchanged
        side_wr(8'd254, 25'd0, 8'h12);
        side_wr(8'd254, 25'd1, 8'h34);
        side_wr(8'd254, 25'd2, 8'h56);
        side_wr(8'd254, 25'd5, 8'h99);
        side_wr(8'd254, 25'd3, 8'hEE);
        side_wr(8'd254, 25'h100, 8'hDD);
        chk("dips_run", {8'h0, dip0, dip1, dip2}, 32'h00123456);

        // Reload from RUN with an out-of-range byte and a DIP write mid-load
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick(2);
        chk("reload_core_reset", 32'(core_reset), 32'd1);
        chk("reload_rom_loaded", 32'(rom_loaded), 32'd1);
        rom_wr(25'h10000, 8'h77, 1'b0);
        chk("ovf_set", 32'(rom_overflow), 32'd1);
        rom_wr(25'h0FFFF, 8'h5A, 1'b1);
        side_wr(8'd254, 25'd1, 8'hC3);
        chk("dip_in_load", {8'h0, dip0, dip1, dip2}, 32'h0012C356);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b0;
        tick(17);
        chk("reload_hold_core_reset", 32'(core_reset), 32'd1);
        tick(1);
        chk("reload_run_core_reset", 32'(core_reset), 32'd0);
        chk("ovf_sticky", 32'(rom_overflow), 32'd1);

        // user_reset in RUN
        user_reset = 1'b1;
        tick(1);
        chk("user_reset_hi", 32'(core_reset), 32'd1);
        user_reset = 1'b0;
        tick(1);
        chk("user_reset_lo", 32'(core_reset), 32'd0);

        // Reset mid-LOAD after two bytes; the write coinciding with reset is lost
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick(1);
        rom_wr(25'd0, 8'hB0, 1'b1);
        rom_wr(25'd1, 8'hB1, 1'b1);
        reset      = 1'b1;
        ioctl_addr = 25'd2;
        ioctl_dout = 8'hB2;
        ioctl_wr   = 1'b1;
        tick(1);
        reset          = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        chk("rst2_rom_loaded", 32'(rom_loaded), 32'd0);
        chk("rst2_overflow",   32'(rom_overflow), 32'd0);
        chk("rst2_dips",       {8'h0, dip0, dip1, dip2}, 32'h00FFFFFF);
        chk("rst2_mod_onehot", 32'(mod_onehot), 32'h1);
        rom_wr(25'd3, 8'hB3, 1'b0);
        tick(20);
        chk("idle_core_reset", 32'(core_reset), 32'd1);
        chk("idle_rom_loaded", 32'(rom_loaded), 32'd0);
        chk("sb_empty",    32'(rom_q.size()), 32'd0);
        chk("dn_wr_count", 32'(n_dn_wr), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
